// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction-memory address and
// loads the IF/ID pipeline register with stall, flush, redirect, halt and fault handling.
module fetch_stage #(
  parameter int unsigned PC_WIDTH    = 16,
  parameter int unsigned INSTR_WIDTH = 16,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned HALT_PC     = 50
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic [PC_WIDTH-1:0]    PC_next,
  output logic [PC_WIDTH-1:0]    ifid_pc,
  output logic [INSTR_WIDTH-1:0] ifid_instr,
  output logic                   ifid_valid,
  output logic                   halted,
  output logic                   addr_fault,
  output logic [31:0]            fetch_count
);

  localparam int unsigned CNT_WIDTH = 32;

  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    ifid_pc_q, ifid_pc_d;
  logic [INSTR_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
  logic                   ifid_valid_q, ifid_valid_d;
  logic                   fault_q, fault_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic                   halt_c;
  logic                   oob_c;

  assign halt_c = (pc_q == PC_WIDTH'(HALT_PC));
  assign oob_c  = (32'(pc_q) >= MEM_DEPTH);

  // Next PC and IF/ID load decisions; reset is applied in the register process.
  always_comb begin
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    fault_d      = fault_q;
    count_d      = count_q;

    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (!(halt_c || stall)) begin
      pc_d = pc_q + PC_WIDTH'(1);
    end

    if (redirect_valid || flush) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = '0;
    end else if (stall) begin
      ifid_valid_d = ifid_valid_q;
    end else if (halt_c) begin
      ifid_valid_d = 1'b0;
    end else if (oob_c) begin
      // Out-of-range fetch becomes a bubble and latches the fault.
      ifid_valid_d = 1'b0;
      fault_d      = 1'b1;
    end else begin
      ifid_pc_d    = pc_q;
      ifid_instr_d = imem_rdata;
      ifid_valid_d = 1'b1;
      if (count_q != '1) begin
        count_d = count_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= PC_WIDTH'(RESET_PC);
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
      ifid_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      count_q      <= '0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      fault_q      <= fault_d;
      count_q      <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign PC_next     = rst ? PC_WIDTH'(RESET_PC) : pc_d;
  assign halted      = halt_c;
  assign ifid_pc     = ifid_pc_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_valid  = ifid_valid_q;
  assign addr_fault  = fault_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: one default instance plus one with a 16-word memory
// for the address-fault case; both see the same control inputs.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, redirect_valid;
  logic [15:0] redirect_pc;

  logic [15:0] addr, rdata, pc_next, ipc, iinstr;
  logic        ivalid, halted, fault;
  logic [31:0] count;

  logic [15:0] f_addr, f_rdata, f_pc_next, f_ipc, f_iinstr;
  logic        f_ivalid, f_halted, f_fault;
  logic [31:0] f_count;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  assign rdata   = 16'hA000 + addr;
  assign f_rdata = 16'hA000 + f_addr;

  fetch_stage dut (
    .clk(clk), .rst(rst), .imem_addr(addr), .imem_rdata(rdata),
    .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .PC_next(pc_next), .ifid_pc(ipc),
    .ifid_instr(iinstr), .ifid_valid(ivalid), .halted(halted),
    .addr_fault(fault), .fetch_count(count)
  );

  fetch_stage #(.MEM_DEPTH(16)) dut_f (
    .clk(clk), .rst(rst), .imem_addr(f_addr), .imem_rdata(f_rdata),
    .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .PC_next(f_pc_next), .ifid_pc(f_ipc),
    .ifid_instr(f_iinstr), .ifid_valid(f_ivalid), .halted(f_halted),
    .addr_fault(f_fault), .fetch_count(f_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // Reset state
    step();
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_valid", 32'(ivalid), 32'd0);
    check("rst_ipc", 32'(ipc), 32'd0);
    check("rst_instr", 32'(iinstr), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_count", count, 32'd0);
    rst = 1'b0;

    // Straight-line fetch
    for (int k = 1; k <= 5; k++) begin
      step();
      check("run_ipc", 32'(ipc), 32'(k - 1));
      check("run_instr", 32'(iinstr), 32'hA000 + 32'(k - 1));
      check("run_valid", 32'(ivalid), 32'd1);
      check("run_count", count, 32'(k));
    end
    check("run_addr", 32'(addr), 32'd5);

    // Stall three edges at pc=5
    stall = 1'b1;
    #1 check("stall_pcnext", 32'(pc_next), 32'd5);
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_addr", 32'(addr), 32'd5);
      check("stall_ipc", 32'(ipc), 32'd4);
      check("stall_instr", 32'(iinstr), 32'hA004);
      check("stall_count", count, 32'd5);
    end
    stall = 1'b0;
    step();
    check("resume_ipc", 32'(ipc), 32'd5);
    check("resume_count", count, 32'd6);
    step();
    check("resume2_ipc", 32'(ipc), 32'd6);
    check("resume2_addr", 32'(addr), 32'd7);

    // Redirect with simultaneous stall at pc=7
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'd20;
    #1 check("redir_pcnext", 32'(pc_next), 32'd20);
    step();
    check("redir_addr", 32'(addr), 32'd20);
    check("redir_valid", 32'(ivalid), 32'd0);
    check("redir_instr", 32'(iinstr), 32'd0);
    check("redir_count", count, 32'd7);
    stall = 1'b0; redirect_valid = 1'b0;
    step();
    check("tgt_ipc", 32'(ipc), 32'd20);
    check("tgt_instr", 32'(iinstr), 32'hA014);
    check("tgt_valid", 32'(ivalid), 32'd1);
    check("tgt_count", count, 32'd8);

    // Free run from reset to the halt PC; small-memory instance faults at 16
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      step();
      if (k == 16) begin
        check("f_last_valid", 32'(f_ivalid), 32'd1);
        check("f_last_ipc", 32'(f_ipc), 32'd15);
        check("f_no_fault", 32'(f_fault), 32'd0);
      end
      if (k == 17) begin
        check("f_fault_set", 32'(f_fault), 32'd1);
        check("f_fault_bubble", 32'(f_ivalid), 32'd0);
        check("f_fault_count", f_count, 32'd16);
      end
    end
    check("halt_addr", 32'(addr), 32'd50);
    check("halt_ipc", 32'(ipc), 32'd49);
    check("halt_valid_last", 32'(ivalid), 32'd1);
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_pcnext", 32'(pc_next), 32'd50);
    for (int k = 0; k < 3; k++) begin
      step();
      check("halt_bubble", 32'(ivalid), 32'd0);
      check("halt_hold", 32'(addr), 32'd50);
      check("halt_count", count, 32'd50);
    end
    check("f_fault_sticky", 32'(f_fault), 32'd1);
    check("f_count_hold", f_count, 32'd16);

    // Redirect out of halt
    redirect_valid = 1'b1; redirect_pc = 16'd10;
    #1 check("unhalt_pcnext", 32'(pc_next), 32'd10);
    step();
    redirect_valid = 1'b0;
    check("unhalt_addr", 32'(addr), 32'd10);
    check("unhalt_flag", 32'(halted), 32'd0);
    check("unhalt_valid", 32'(ivalid), 32'd0);
    step();
    check("unhalt_ipc", 32'(ipc), 32'd10);
    check("unhalt_instr", 32'(iinstr), 32'hA00A);
    check("unhalt_count", count, 32'd51);

    // Mid-stream reset with conflicting inputs asserted
    rst = 1'b1;
    step();
    check("f_fault_clr", 32'(f_fault), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) step();
    check("pre_rst_count", count, 32'd12);
    check("pre_rst_valid", 32'(ivalid), 32'd1);
    rst = 1'b1; stall = 1'b1; flush = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'd33;
    #1 check("rst_pcnext", 32'(pc_next), 32'd0);
    step();
    check("rst2_addr", 32'(addr), 32'd0);
    check("rst2_valid", 32'(ivalid), 32'd0);
    check("rst2_ipc", 32'(ipc), 32'd0);
    check("rst2_instr", 32'(iinstr), 32'd0);
    check("rst2_count", count, 32'd0);
    check("rst2_fault", 32'(fault), 32'd0);
    rst = 1'b0; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;

    // Flush alone: bubble, PC keeps advancing
    step();
    step();
    check("pre_flush_ipc", 32'(ipc), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_valid", 32'(ivalid), 32'd0);
    check("flush_instr", 32'(iinstr), 32'd0);
    check("flush_addr", 32'(addr), 32'd3);
    step();
    check("post_flush_ipc", 32'(ipc), 32'd3);
    check("post_flush_valid", 32'(ivalid), 32'd1);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    step();
    redirect_valid = 1'b0;
    #1 check("wrap_pcnext", 32'(pc_next), 32'd0);
    step();
    check("wrap_addr", 32'(addr), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
